// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
//   state_e : arbiter FSM state (IDLE, WAIT_RSP)
//   owner_e : port that owns the outstanding read (OWN_IMEM = 0, OWN_DMEM = 1)
//   RST_PTR : preferred port after reset; also the fixed winner when round-robin is off
package mem_arb_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } state_e;

  typedef enum logic {
    OWN_IMEM = 1'b0,
    OWN_DMEM = 1'b1
  } owner_e;

  localparam owner_e RST_PTR = OWN_DMEM;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the core-side (imem/dmem) and memory-side request/response signals.
// Modports:
//   master : arbiter view (takes core requests, drives grants/rvalids and the memory bus)
//   slave  : environment view (core ports and RAM)
interface mem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          imem_req_i;
  logic [AW-1:0] imem_addr_i;
  logic          imem_gnt_o;
  logic          imem_rvalid_o;
  logic [DW-1:0] imem_rdata_o;

  logic          dmem_req_i;
  logic          dmem_we_i;
  logic [AW-1:0] dmem_addr_i;
  logic [DW-1:0] dmem_wdata_i;
  logic          dmem_gnt_o;
  logic          dmem_rvalid_o;
  logic [DW-1:0] dmem_rdata_o;

  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_gnt_i;
  logic          mem_rvalid_i;
  logic [DW-1:0] mem_rdata_i;

  modport master (
    input  imem_req_i, imem_addr_i,
    input  dmem_req_i, dmem_we_i, dmem_addr_i, dmem_wdata_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output imem_gnt_o, imem_rvalid_o, imem_rdata_o,
    output dmem_gnt_o, dmem_rvalid_o, dmem_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport slave (
    output imem_req_i, imem_addr_i,
    output dmem_req_i, dmem_we_i, dmem_addr_i, dmem_wdata_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  imem_gnt_o, imem_rvalid_o, imem_rdata_o,
    input  dmem_gnt_o, dmem_rvalid_o, dmem_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/arb_pick2.sv
// Two-way request picker producing a one-hot winner.
// Configuration macro: MEM_ARB_RR_EN
//   defined   : on contention the port named by ptr wins (round-robin)
//   undefined : on contention dmem always wins; the ptr port does not exist
// Ports:
//   req : request bits, [0] = imem, [1] = dmem
//   ptr : preferred port on contention (round-robin build only)
//   gnt : one-hot winner, same bit order as req; zero when nothing requests
module arb_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
`ifdef MEM_ARB_RR_EN
  input  owner_e     ptr,
`endif
  output logic [1:0] gnt
);

  owner_e pref;

`ifdef MEM_ARB_RR_EN
  assign pref = ptr;
`else
  assign pref = RST_PTR;
`endif

  always_comb begin
    gnt = req;
    if (&req) begin
      gnt = (pref == OWN_DMEM) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between the rv32i fetch (imem) and data (dmem) ports.
// One requester is forwarded per transaction; at most one read is outstanding and
// its response is routed back to the port that issued it.
// Configuration macro: MEM_ARB_RR_EN (defined = round-robin, undefined = dmem first).
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : mem_arbiter_if.master -- imem_*/dmem_* core ports and mem_* RAM port
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input logic           clk,
  input logic           reset,
  mem_arbiter_if.master bus
);

  state_e        state_q;
  owner_e        owner_q;
  logic [1:0]    req;
  logic [1:0]    win;
  logic          fwd;
  logic          accept;
  logic          rsp;
  logic          we_mux;
  logic [AW-1:0] addr_mux;
  logic [DW-1:0] wdata_mux;

  assign req = {bus.dmem_req_i, bus.imem_req_i};

`ifdef MEM_ARB_RR_EN
  owner_e ptr_q;

  arb_pick2 u_pick (
    .req (req),
    .ptr (ptr_q),
    .gnt (win)
  );
`else
  arb_pick2 u_pick (
    .req (req),
    .gnt (win)
  );
`endif

  // Forwarding depends only on registered state, so mem_rvalid_i never reaches mem_req_o.
  assign fwd    = (state_q == IDLE) && (|req);
  assign accept = fwd && bus.mem_gnt_i;
  assign rsp    = (state_q == WAIT_RSP) && bus.mem_rvalid_i;

  always_comb begin
    we_mux    = 1'b0;
    addr_mux  = '0;
    wdata_mux = '0;
    if (fwd) begin
      if (win[1]) begin
        we_mux    = bus.dmem_we_i;
        addr_mux  = bus.dmem_addr_i;
        wdata_mux = bus.dmem_wdata_i;
      end else begin
        addr_mux  = bus.imem_addr_i;
      end
    end
  end

  assign bus.mem_req_o   = fwd;
  assign bus.mem_we_o    = we_mux;
  assign bus.mem_addr_o  = addr_mux;
  assign bus.mem_wdata_o = wdata_mux;

  assign bus.imem_gnt_o  = accept && win[0];
  assign bus.dmem_gnt_o  = accept && win[1];

  assign bus.imem_rvalid_o = rsp && (owner_q == OWN_IMEM);
  assign bus.dmem_rvalid_o = rsp && (owner_q == OWN_DMEM);
  assign bus.imem_rdata_o  = bus.mem_rdata_i;
  assign bus.dmem_rdata_o  = bus.mem_rdata_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= OWN_IMEM;
`ifdef MEM_ARB_RR_EN
      ptr_q   <= RST_PTR;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          // Writes complete at the grant; only reads wait for a response.
          if (accept && !we_mux) begin
            state_q <= WAIT_RSP;
            owner_q <= win[1] ? OWN_DMEM : OWN_IMEM;
          end
        end
        WAIT_RSP: begin
          if (bus.mem_rvalid_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
`ifdef MEM_ARB_RR_EN
      // Prefer the port that did not just win.
      if (accept) begin
        ptr_q <= win[1] ? OWN_IMEM : OWN_DMEM;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random traffic
// checked against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state: one outstanding read and the port granted last.
  bit m_busy;
  bit m_own_d;
  bit m_last_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.imem_req_i   = 1'b0;
    bus.imem_addr_i  = '0;
    bus.dmem_req_i   = 1'b0;
    bus.dmem_we_i    = 1'b0;
    bus.dmem_addr_i  = '0;
    bus.dmem_wdata_i = '0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_mem_req"},     32'(bus.mem_req_o),     32'd0);
    chk({tag, "_mem_we"},      32'(bus.mem_we_o),      32'd0);
    chk({tag, "_mem_addr"},    bus.mem_addr_o,         32'd0);
    chk({tag, "_mem_wdata"},   bus.mem_wdata_o,        32'd0);
    chk({tag, "_imem_gnt"},    32'(bus.imem_gnt_o),    32'd0);
    chk({tag, "_dmem_gnt"},    32'(bus.dmem_gnt_o),    32'd0);
    chk({tag, "_imem_rvalid"}, 32'(bus.imem_rvalid_o), 32'd0);
    chk({tag, "_dmem_rvalid"}, 32'(bus.dmem_rvalid_o), 32'd0);
  endtask

  initial begin
    bit exp_win_d [3];
    bit ir, dr, win_d, exp_req, exp_we, acc;
    logic [31:0] exp_addr, exp_wdata;
`ifdef MEM_ARB_RR_EN
    exp_win_d = '{1'b1, 1'b0, 1'b1};
`else
    exp_win_d = '{1'b1, 1'b1, 1'b1};
`endif

    // Reset values
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
    settle();
    chk_quiet("reset");

    // Lone fetch
    bus.imem_req_i  = 1'b1;
    bus.imem_addr_i = 32'h10;
    bus.mem_gnt_i   = 1'b1;
    settle();
    chk("fetch_imem_gnt", 32'(bus.imem_gnt_o), 32'd1);
    chk("fetch_dmem_gnt", 32'(bus.dmem_gnt_o), 32'd0);
    chk("fetch_mem_req",  32'(bus.mem_req_o),  32'd1);
    chk("fetch_mem_addr", bus.mem_addr_o,      32'h10);
    chk("fetch_mem_we",   32'(bus.mem_we_o),   32'd0);
    tick();
    idle_inputs();
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h0050_0093;
    settle();
    chk("fetch_imem_rvalid", 32'(bus.imem_rvalid_o), 32'd1);
    chk("fetch_imem_rdata",  bus.imem_rdata_o,       32'h0050_0093);
    chk("fetch_dmem_rvalid", 32'(bus.dmem_rvalid_o), 32'd0);
    chk("fetch_wait_req",    32'(bus.mem_req_o),     32'd0);
    tick();

    // Data write
    idle_inputs();
    bus.dmem_req_i   = 1'b1;
    bus.dmem_we_i    = 1'b1;
    bus.dmem_addr_i  = 32'h40;
    bus.dmem_wdata_i = 32'hDEAD_BEEF;
    bus.mem_gnt_i    = 1'b1;
    settle();
    chk("write_mem_we",    32'(bus.mem_we_o),   32'd1);
    chk("write_mem_addr",  bus.mem_addr_o,      32'h40);
    chk("write_mem_wdata", bus.mem_wdata_o,     32'hDEAD_BEEF);
    chk("write_dmem_gnt",  32'(bus.dmem_gnt_o), 32'd1);
    chk("write_imem_gnt",  32'(bus.imem_gnt_o), 32'd0);
    tick();
    // Still IDLE: a fetch is forwarded at once, and a stray rvalid is dropped.
    idle_inputs();
    bus.imem_req_i   = 1'b1;
    bus.imem_addr_i  = 32'h14;
    bus.mem_gnt_i    = 1'b1;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h1234_5678;
    settle();
    chk("after_write_imem_gnt", 32'(bus.imem_gnt_o),    32'd1);
    chk("stale_imem_rvalid",    32'(bus.imem_rvalid_o), 32'd0);
    chk("stale_dmem_rvalid",    32'(bus.dmem_rvalid_o), 32'd0);
    tick();
    idle_inputs();
    bus.mem_rvalid_i = 1'b1;
    settle();
    chk("after_write_rvalid", 32'(bus.imem_rvalid_o), 32'd1);
    tick();

    // Contention: both read every cycle
    for (int k = 0; k < 3; k++) begin
      idle_inputs();
      bus.imem_req_i  = 1'b1;
      bus.imem_addr_i = 32'h100 + 32'(4 * k);
      bus.dmem_req_i  = 1'b1;
      bus.dmem_addr_i = 32'h200 + 32'(4 * k);
      bus.mem_gnt_i   = 1'b1;
      settle();
      chk($sformatf("cont%0d_dmem_gnt", k), 32'(bus.dmem_gnt_o), 32'(exp_win_d[k]));
      chk($sformatf("cont%0d_imem_gnt", k), 32'(bus.imem_gnt_o), 32'(!exp_win_d[k]));
      chk($sformatf("cont%0d_mem_addr", k), bus.mem_addr_o,
          exp_win_d[k] ? 32'h200 + 32'(4 * k) : 32'h100 + 32'(4 * k));
      tick();
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = 32'(k);
      settle();
      chk($sformatf("cont%0d_wait_req", k), 32'(bus.mem_req_o),     32'd0);
      chk($sformatf("cont%0d_drv", k),      32'(bus.dmem_rvalid_o), 32'(exp_win_d[k]));
      chk($sformatf("cont%0d_irv", k),      32'(bus.imem_rvalid_o), 32'(!exp_win_d[k]));
      tick();
    end

    // Memory backpressure
    idle_inputs();
    bus.dmem_req_i  = 1'b1;
    bus.dmem_addr_i = 32'h300;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk($sformatf("bp%0d_dmem_gnt", k), 32'(bus.dmem_gnt_o), 32'd0);
      chk($sformatf("bp%0d_mem_req", k),  32'(bus.mem_req_o),  32'd1);
      chk($sformatf("bp%0d_mem_addr", k), bus.mem_addr_o,      32'h300);
      tick();
    end
    bus.mem_gnt_i = 1'b1;
    settle();
    chk("bp_final_dmem_gnt", 32'(bus.dmem_gnt_o), 32'd1);
    tick();

    // Slow response with a fetch waiting
    idle_inputs();
    bus.imem_req_i  = 1'b1;
    bus.imem_addr_i = 32'h400;
    bus.mem_gnt_i   = 1'b1;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk($sformatf("slow%0d_mem_req", k),  32'(bus.mem_req_o),  32'd0);
      chk($sformatf("slow%0d_imem_gnt", k), 32'(bus.imem_gnt_o), 32'd0);
      chk($sformatf("slow%0d_drv", k),      32'(bus.dmem_rvalid_o), 32'd0);
      tick();
    end
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hCAFE_F00D;
    settle();
    chk("slow_dmem_rvalid", 32'(bus.dmem_rvalid_o), 32'd1);
    chk("slow_imem_rvalid", 32'(bus.imem_rvalid_o), 32'd0);
    chk("slow_dmem_rdata",  bus.dmem_rdata_o,       32'hCAFE_F00D);
    chk("slow_rsp_mem_req", 32'(bus.mem_req_o),     32'd0);
    tick();
    bus.mem_rvalid_i = 1'b0;
    settle();
    chk("slow_next_imem_gnt", 32'(bus.imem_gnt_o), 32'd1);
    chk("slow_next_mem_addr", bus.mem_addr_o,      32'h400);
    tick();

    // Reset while a fetch is outstanding, then a late response
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h5555_AAAA;
    settle();
    chk_quiet("rst_mid");
    tick();

    // Leave the pointer favouring imem, then reset and contend: dmem must win.
    idle_inputs();
    bus.dmem_req_i = 1'b1;
    bus.dmem_we_i  = 1'b1;
    bus.mem_gnt_i  = 1'b1;
    settle();
    chk("pre_rst_write_gnt", 32'(bus.dmem_gnt_o), 32'd1);
    tick();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.imem_req_i = 1'b1;
    bus.dmem_req_i = 1'b1;
    bus.mem_gnt_i  = 1'b1;
    settle();
    chk("rst_exit_dmem_gnt", 32'(bus.dmem_gnt_o), 32'd1);
    chk("rst_exit_imem_gnt", 32'(bus.imem_gnt_o), 32'd0);
    tick();

    // Random traffic against the model
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_busy   = 1'b0;
    m_own_d  = 1'b0;
    m_last_d = 1'b0;
    for (int i = 0; i < 400; i++) begin
      ir = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      bus.imem_req_i   = ir;
      bus.imem_addr_i  = $urandom;
      bus.dmem_req_i   = dr;
      bus.dmem_we_i    = 1'($urandom_range(0, 1));
      bus.dmem_addr_i  = $urandom;
      bus.dmem_wdata_i = $urandom;
      bus.mem_gnt_i    = ($urandom_range(0, 3) != 0);
      bus.mem_rvalid_i = 1'($urandom_range(0, 1));
      bus.mem_rdata_i  = $urandom;
      settle();

`ifdef MEM_ARB_RR_EN
      win_d = (ir && dr) ? !m_last_d : dr;
`else
      win_d = dr;
`endif
      exp_req   = !m_busy && (ir || dr);
      exp_we    = exp_req && win_d && bus.dmem_we_i;
      exp_addr  = !exp_req ? 32'd0 : (win_d ? bus.dmem_addr_i : bus.imem_addr_i);
      exp_wdata = (exp_req && win_d) ? bus.dmem_wdata_i : 32'd0;
      acc       = exp_req && bus.mem_gnt_i;

      chk($sformatf("rnd%0d_mem_req", i),   32'(bus.mem_req_o),   32'(exp_req));
      chk($sformatf("rnd%0d_mem_we", i),    32'(bus.mem_we_o),    32'(exp_we));
      chk($sformatf("rnd%0d_mem_addr", i),  bus.mem_addr_o,       exp_addr);
      chk($sformatf("rnd%0d_mem_wdata", i), bus.mem_wdata_o,      exp_wdata);
      chk($sformatf("rnd%0d_imem_gnt", i),  32'(bus.imem_gnt_o),  32'(acc && !win_d));
      chk($sformatf("rnd%0d_dmem_gnt", i),  32'(bus.dmem_gnt_o),  32'(acc && win_d));
      chk($sformatf("rnd%0d_imem_rv", i),   32'(bus.imem_rvalid_o),
          32'(m_busy && bus.mem_rvalid_i && !m_own_d));
      chk($sformatf("rnd%0d_dmem_rv", i),   32'(bus.dmem_rvalid_o),
          32'(m_busy && bus.mem_rvalid_i && m_own_d));
      chk($sformatf("rnd%0d_irdata", i),    bus.imem_rdata_o,     bus.mem_rdata_i);
      chk($sformatf("rnd%0d_drdata", i),    bus.dmem_rdata_o,     bus.mem_rdata_i);

      if (m_busy && bus.mem_rvalid_i) begin
        m_busy = 1'b0;
      end else if (acc && !exp_we) begin
        m_busy  = 1'b1;
        m_own_d = win_d;
      end
      if (acc) m_last_d = win_d;
      tick();
    end

    idle_inputs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
